decoder_scan_seq: RTL
=====================

Name: decoder_scan_seq

Overview:
Parametrised, registered one-hot decoder. Generalises the fixed 3-to-8 combinational decoder to SEL_W-to-2**SEL_W. Adds a registered direct-decode mode with valid handshake and an autonomous scan mode that walks the one-hot output with a programmable dwell, for LED/keypad row strobing. Sits between control logic and display or matrix drivers.

Parameters:
SEL_W, 3, select width; output width OUT_W = 2**SEL_W (localparam); legal range 1..6
DWELL, 4, clock cycles each output stays active in scan mode; must be >= 1

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising clk
en  input  1  block enable; low forces out to zero and freezes state
mode  input  1  0 = direct decode, 1 = auto scan
in_valid  input  1  sel qualifier; one-cycle load strobe
sel  input  SEL_W  index to decode (direct) or jump to (scan)
out  output  OUT_W  registered one-hot output, or all-zero
out_valid  output  1  one-cycle pulse when out takes a new index
idx  output  SEL_W  registered current index
wrap  output  1  one-cycle pulse on scan cycle completion

Behaviour:
- Reset (rst_n low at clk edge): out=0, idx=0, dwell counter=0, out_valid=0, wrap=0, scan direction=up. Reset has priority over all inputs, including mid-scan.
- Invariant: out is always either all-zero or exactly one-hot with bit idx set.
- en=0: next out=0, out_valid=0, wrap=0. idx, dwell counter and direction hold. in_valid is ignored.
- On return to en=1: out=1<<idx on the next edge if mode=1. If mode=0, out stays 0 until the next in_valid.
- Direct mode (mode=0, en=1):
  - If in_valid: idx<=sel, out<=1<<sel, out_valid<=1. Latency is 1 clk from the sel sample to out.
  - Otherwise: out and idx hold, out_valid<=0.
  - Dwell counter is held at 0. wrap is always 0.
- Scan mode (mode=1, en=1):
  - out<=1<<idx every cycle.
  - Dwell counter (width max(1,$clog2(DWELL))) counts 0..DWELL-1.
  - At DWELL-1: counter<=0, idx advances to the next index, out_valid<=1.
  - Default advance is idx+1 mod OUT_W.
  - wrap<=1 in the same cycle idx goes OUT_W-1 -> 0.
  - DWELL=1: idx advances every cycle and out_valid stays high continuously.
- Scan with in_valid (jump has priority over advance): idx<=sel, counter<=0, out<=1<<sel, out_valid<=1, wrap<=0. Scan direction is unchanged.
- Mode change 0->1: scan starts from the current idx with counter=0. The first advance occurs DWELL cycles later.
- Mode change 1->0: out and idx freeze at their current values; the counter clears.
- SEL_W=1: OUT_W=2; scan toggles between 0 and 1, and wrap pulses on each 1->0 transition.

Optional Feature:
SCAN_BOUNCE_EN
- Defined: scan runs ping-pong 0,1..OUT_W-1,OUT_W-2..0,1...
  - Direction register: reset=up. Flips to down on reaching OUT_W-1 and to up on reaching 0.
  - wrap pulses on the advance that lands on idx=0; the cycle is complete when it returns to 0.
  - A jump via in_valid keeps the current direction. Endpoint checks still apply after a jump.
- Not defined: modular increment only; no direction register is synthesised.

Test Plan:
- Reset: rst_n=0 for 2 clks mid-scan with idx=5 -> out=8'h00, idx=0, out_valid=0, wrap=0 on the first edge with reset sampled low.
- Direct decode: mode=0, en=1, in_valid pulse with sel=3'b110 -> the next edge gives out=8'h40, idx=6, out_valid=1 for 1 clk. out stays 8'h40 while in_valid=0.
- Scan timing (DWELL=4): mode=1 from idx=0 -> out=01 for 4 clks, then 02, ... 80. On 80->01, wrap=1 and out_valid=1 for exactly 1 clk. Full period is 32 clks.
- Scan jump: during scan with idx=2 at dwell=1, in_valid with sel=7 -> next out=8'h80, counter=0, out_valid=1. The next advance comes 4 clks later to 8'h01 with wrap=1.
- Enable gating: en=0 for 5 clks at idx=4 during scan -> out=0 and no pulses. On en=1, out=8'h10 resumes with a full 4-clk dwell. in_valid while en=0 has no effect.
- Bounce (SCAN_BOUNCE_EN, DWELL=1, SEL_W=2) -> idx sequence 0,1,2,3,2,1,0,1. wrap=1 only on the cycle idx becomes 0.

Source files
------------

// File: rtl/decoder_scan_seq.sv
// Registered SEL_W-to-2**SEL_W one-hot decoder with direct-load and auto-scan modes.
// Optional `SCAN_BOUNCE_EN makes the scan ping-pong instead of wrapping modulo OUT_W.
module decoder_scan_seq #(
    parameter int unsigned SEL_W = 3,
    parameter int unsigned DWELL = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  mode,
    input  logic                  in_valid,
    input  logic [SEL_W-1:0]      sel,
    output logic [2**SEL_W-1:0]   out,
    output logic                  out_valid,
    output logic [SEL_W-1:0]      idx,
    output logic                  wrap
);

    localparam int unsigned OUT_W = 2**SEL_W;
    localparam int unsigned CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
    localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(OUT_W - 1);
    localparam logic [OUT_W-1:0] ONE = OUT_W'(1);

    logic [OUT_W-1:0] out_q, out_d;
    logic [SEL_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ov_q, ov_d;
    logic             wrap_q, wrap_d;
    logic [SEL_W-1:0] nxt_idx;

`ifdef SCAN_BOUNCE_EN
    logic dir_q, dir_d, go_down;

    // Endpoints override the stored direction so a jump onto an end still turns around.
    always_comb begin
        if (idx_q == IDX_LAST) begin
            go_down = 1'b1;
        end else if (idx_q == '0) begin
            go_down = 1'b0;
        end else begin
            go_down = dir_q;
        end
        nxt_idx = go_down ? idx_q - SEL_W'(1) : idx_q + SEL_W'(1);
    end
`else
    assign nxt_idx = idx_q + SEL_W'(1);
`endif

    always_comb begin
        out_d  = out_q;
        idx_d  = idx_q;
        cnt_d  = cnt_q;
        ov_d   = 1'b0;
        wrap_d = 1'b0;
`ifdef SCAN_BOUNCE_EN
        dir_d  = dir_q;
`endif
        if (!en) begin
            out_d = '0;
        end else if (!mode) begin
            cnt_d = '0;
            if (in_valid) begin
                idx_d = sel;
                out_d = ONE << sel;
                ov_d  = 1'b1;
            end
        end else begin
            if (in_valid) begin
                idx_d = sel;
                cnt_d = '0;
                ov_d  = 1'b1;
            end else if (cnt_q == CNT_LAST) begin
                cnt_d  = '0;
                idx_d  = nxt_idx;
                ov_d   = 1'b1;
                wrap_d = (nxt_idx == '0);
`ifdef SCAN_BOUNCE_EN
                dir_d  = go_down;
`endif
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            out_d = ONE << idx_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q  <= '0;
            idx_q  <= '0;
            cnt_q  <= '0;
            ov_q   <= 1'b0;
            wrap_q <= 1'b0;
`ifdef SCAN_BOUNCE_EN
            dir_q  <= 1'b0;
`endif
        end else begin
            out_q  <= out_d;
            idx_q  <= idx_d;
            cnt_q  <= cnt_d;
            ov_q   <= ov_d;
            wrap_q <= wrap_d;
`ifdef SCAN_BOUNCE_EN
            dir_q  <= dir_d;
`endif
        end
    end

    assign out       = out_q;
    assign idx       = idx_q;
    assign out_valid = ov_q;
    assign wrap      = wrap_q;

endmodule
